// File: rtl/conversor_saida_bcd.sv
// Signed binary-to-BCD output converter: captures a register value on request and
// converts its magnitude to three BCD digits plus sign, saturating above 999.
module conversor_saida_bcd #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicia,
  input  logic [LARGURA-1:0] dado,
  output logic               ocupado,
  output logic               pronto,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade,
  output logic               indicaNegativo,
  output logic               estouro
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(32'd999);

  estado_t             estado_q, estado_d;
  logic [3:0]          contador_q, contador_d;
  logic                sinal_q, sinal_d;
  logic                ovf_q, ovf_d;
  logic [9:0]          bin_q, bin_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [3:0]          centena_q, centena_d;
  logic [3:0]          dezena_q, dezena_d;
  logic [3:0]          unidade_q, unidade_d;
  logic                negativo_q, negativo_d;
  logic                estouro_q, estouro_d;
  logic                pronto_q, pronto_d;
  logic                ocupado_q, ocupado_d;
  logic [LARGURA-1:0]  magnitude_s;
  logic [11:0]         ajustado_s;

  function automatic logic [3:0] ajusta(input logic [3:0] digito);
    if (digito >= 4'd5) begin
      return digito + 4'd3;
    end else begin
      return digito;
    end
  endfunction

  // Two's-complement magnitude; the most negative value maps to 2^(LARGURA-1).
  assign magnitude_s = dado[LARGURA-1] ? (~dado + {{(LARGURA-1){1'b0}}, 1'b1}) : dado;

  // Digit correction applied before every shift of the double-dabble register.
  assign ajustado_s = {ajusta(bcd_q[11:8]), ajusta(bcd_q[7:4]), ajusta(bcd_q[3:0])};

  // Next-state and next-output logic of the conversion sequencer.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    sinal_d    = sinal_q;
    ovf_d      = ovf_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    centena_d  = centena_q;
    dezena_d   = dezena_q;
    unidade_d  = unidade_q;
    negativo_d = negativo_q;
    estouro_d  = estouro_q;
    pronto_d   = 1'b0;
    ocupado_d  = ocupado_q;

    case (estado_q)
      OCIOSO: begin
        if (inicia) begin
          sinal_d    = dado[LARGURA-1];
          ovf_d      = (magnitude_s > LIMITE);
          bin_d      = magnitude_s[9:0];
          bcd_d      = 12'd0;
          contador_d = 4'd10;
          estado_d   = DESLOCA;
          ocupado_d  = 1'b1;
        end else begin
          ocupado_d  = 1'b0;
        end
      end
      DESLOCA: begin
        {bcd_d, bin_d} = {ajustado_s, bin_q} << 5'd1;
        contador_d     = contador_q - 4'd1;
        ocupado_d      = 1'b1;
        if (contador_q == 4'd1) begin
          estado_d = FIM;
        end else begin
          estado_d = DESLOCA;
        end
      end
      FIM: begin
        if (ovf_q) begin
          centena_d = 4'd9;
          dezena_d  = 4'd9;
          unidade_d = 4'd9;
        end else begin
          centena_d = bcd_q[11:8];
          dezena_d  = bcd_q[7:4];
          unidade_d = bcd_q[3:0];
        end
        negativo_d = sinal_q;
        estouro_d  = ovf_q;
        pronto_d   = 1'b1;
        ocupado_d  = 1'b0;
        estado_d   = OCIOSO;
      end
      default: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      contador_q <= 4'd0;
      sinal_q    <= 1'b0;
      ovf_q      <= 1'b0;
      bin_q      <= 10'd0;
      bcd_q      <= 12'd0;
      centena_q  <= 4'd0;
      dezena_q   <= 4'd0;
      unidade_q  <= 4'd0;
      negativo_q <= 1'b0;
      estouro_q  <= 1'b0;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      sinal_q    <= sinal_d;
      ovf_q      <= ovf_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      centena_q  <= centena_d;
      dezena_q   <= dezena_d;
      unidade_q  <= unidade_d;
      negativo_q <= negativo_d;
      estouro_q  <= estouro_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign ocupado        = ocupado_q;
  assign pronto         = pronto_q;
  assign centena        = centena_q;
  assign dezena         = dezena_q;
  assign unidade        = unidade_q;
  assign indicaNegativo = negativo_q;
  assign estouro        = estouro_q;

endmodule
